// File: rtl/enemy_spawner.sv
// Enemy spawner: counts enemies on the level grid, then places new ones on random air cells.
module enemy_spawner #(
    parameter int unsigned GRID_W      = 40,
    parameter int unsigned GRID_H      = 30,
    parameter int unsigned MAX_ENEMIES = 8,
    parameter int unsigned MAX_TRIES   = 64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    input  logic [5:0] player_x,
    input  logic [4:0] player_y,
    output logic [5:0] grid_x,
    output logic [4:0] grid_y,
    input  logic [2:0] grid_out,
    output logic       grid_write,
    output logic [2:0] grid_in,
    output logic [5:0] enemy_count,
    output logic [5:0] spawned_count
);

    localparam logic [2:0]  CELL_AIR   = 3'd0;
    localparam logic [2:0]  CELL_ENEMY = 3'd4;
    localparam logic [15:0] LFSR_MASK  = 16'hB400;
    localparam logic [5:0]  LAST_X     = 6'(GRID_W - 1);
    localparam logic [4:0]  LAST_Y     = 5'(GRID_H - 1);
    localparam logic [5:0]  COUNT_MAX  = 6'd63;

    typedef enum logic [3:0] {
        IDLE, SCAN_A, SCAN_W, SCAN_R, CHECK, PICK,
        PROBE_A, PROBE_W, PROBE_R, WRITE, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr;
    logic [5:0]  scan_x, scan_x_nxt, cx, cx_nxt;
    logic [4:0]  scan_y, scan_y_nxt, cy, cy_nxt;
    logic [6:0]  tries, tries_nxt;
    logic [5:0]  enemy_count_nxt, spawned_count_nxt;
    logic [5:0]  grid_x_nxt;
    logic [4:0]  grid_y_nxt;
    logic [2:0]  grid_in_nxt;
    logic        grid_write_nxt, done_nxt;

    logic [5:0]  cand_x;
    logic [4:0]  cand_y;
    logic        reject;
    logic        scan_last;

    assign cand_x    = lfsr[5:0];
    assign cand_y    = lfsr[12:8];
    assign reject    = ({1'b0, cand_x} >= 7'(GRID_W)) || ({1'b0, cand_y} >= 6'(GRID_H))
                       || ((cand_x == player_x) && (cand_y == player_y));
    assign scan_last = (scan_x == LAST_X) && (scan_y == LAST_Y);

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN_A;
            SCAN_A:  state_nxt = SCAN_W;
            SCAN_W:  state_nxt = SCAN_R;
            SCAN_R:  state_nxt = scan_last ? CHECK : SCAN_A;
            CHECK:   state_nxt = ((enemy_count >= 6'(MAX_ENEMIES)) || (tries == 7'(MAX_TRIES)))
                                 ? DONE : PICK;
            PICK:    state_nxt = reject ? CHECK : PROBE_A;
            PROBE_A: state_nxt = PROBE_W;
            PROBE_W: state_nxt = PROBE_R;
            PROBE_R: state_nxt = (grid_out == CELL_AIR) ? WRITE : CHECK;
            WRITE:   state_nxt = CHECK;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for datapath registers and registered outputs
    always_comb begin
        scan_x_nxt        = scan_x;
        scan_y_nxt        = scan_y;
        cx_nxt            = cx;
        cy_nxt            = cy;
        tries_nxt         = tries;
        enemy_count_nxt   = enemy_count;
        spawned_count_nxt = spawned_count;
        grid_x_nxt        = grid_x;
        grid_y_nxt        = grid_y;
        grid_in_nxt       = grid_in;
        grid_write_nxt    = (state_nxt == WRITE);
        done_nxt          = (state_nxt == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    scan_x_nxt        = 6'd0;
                    scan_y_nxt        = 5'd0;
                    tries_nxt         = 7'd0;
                    enemy_count_nxt   = 6'd0;
                    spawned_count_nxt = 6'd0;
                end
            end
            SCAN_A: begin
                grid_x_nxt = scan_x;
                grid_y_nxt = scan_y;
            end
            SCAN_R: begin
                if ((grid_out == CELL_ENEMY) && (enemy_count != COUNT_MAX))
                    enemy_count_nxt = enemy_count + 6'd1;
                if (scan_x == LAST_X) begin
                    scan_x_nxt = 6'd0;
                    scan_y_nxt = scan_y + 5'd1;
                end else begin
                    scan_x_nxt = scan_x + 6'd1;
                end
            end
            PICK: begin
                tries_nxt = tries + 7'd1;
                if (!reject) begin
                    cx_nxt = cand_x;
                    cy_nxt = cand_y;
                end
            end
            PROBE_A: begin
                grid_x_nxt = cx;
                grid_y_nxt = cy;
            end
            WRITE: begin
                if (enemy_count != COUNT_MAX)   enemy_count_nxt   = enemy_count + 6'd1;
                if (spawned_count != COUNT_MAX) spawned_count_nxt = spawned_count + 6'd1;
            end
            default: ;
        endcase
        if (state_nxt == WRITE) grid_in_nxt = CELL_ENEMY;
    end

    // Datapath, LFSR and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr          <= LFSR_SEED;
            scan_x        <= 6'd0;
            scan_y        <= 5'd0;
            cx            <= 6'd0;
            cy            <= 5'd0;
            tries         <= 7'd0;
            enemy_count   <= 6'd0;
            spawned_count <= 6'd0;
            grid_x        <= 6'd0;
            grid_y        <= 5'd0;
            grid_in       <= 3'd0;
            grid_write    <= 1'b0;
            done          <= 1'b0;
        end else begin
            lfsr          <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
            scan_x        <= scan_x_nxt;
            scan_y        <= scan_y_nxt;
            cx            <= cx_nxt;
            cy            <= cy_nxt;
            tries         <= tries_nxt;
            enemy_count   <= enemy_count_nxt;
            spawned_count <= spawned_count_nxt;
            grid_x        <= grid_x_nxt;
            grid_y        <= grid_y_nxt;
            grid_in       <= grid_in_nxt;
            grid_write    <= grid_write_nxt;
            done          <= done_nxt;
        end
    end

endmodule
